// File: rtl/ab_req_pairer_pkg.sv
// ============================================================================
// Module      : ab_pkg
// Description : Shared types and default widths for the A/B request pairer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ab_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 24;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } ab_pair_t;

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

`default_nettype wire

// File: rtl/ab_req_pairer_if.sv
// ============================================================================
// Module      : ab_req_pairer_if
// Description : A/B beat inputs plus the paired valid/ready write request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ab_req_pairer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 24
);
    logic              valid_addr;
    logic [ADDR_W-1:0] address;
    logic              valid_data;
    logic [DATA_W-1:0] data;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    // master: agents A/B and the downstream memory model
    modport master (
        output valid_addr, address, valid_data, data, wr_ready,
        input  wr_valid, wr_addr, wr_data
    );

    // slave: the pairer itself
    modport slave (
        input  valid_addr, address, valid_data, data, wr_ready,
        output wr_valid, wr_addr, wr_data
    );
endinterface

`default_nettype wire

// File: rtl/ab_sync_fifo.sv
// ============================================================================
// Module      : ab_sync_fifo
// Description : Single-clock FIFO, wrapping pointers, first-word fall-through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ab_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              push,
    input  wire logic              pop,
    input  wire logic [WIDTH-1:0]  din,
    output logic      [WIDTH-1:0]  dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W:0]   r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + 1'b1;
            if (pop)  r_rptr <= r_rptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wptr] <= din;
    end

    assign dout  = r_mem[r_rptr];
    assign count = r_count;
    assign full  = (r_count == (c_PTR_W+1)'(DEPTH));
    assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/ab_req_pairer.sv
// ============================================================================
// Module      : ab_req_pairer
// Description : Buffers A (address) and B (data) beats, pairs them in order
//               and presents write requests through a valid/ready register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ab_req_pairer
    import ab_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    ab_req_pairer_if.slave        bus,
    output logic                  addr_ovf,
    output logic                  data_ovf,
    input  wire logic             clr_err,
    output logic [CNT_W-1:0]      pair_count
);
    localparam int c_CNT_FW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]   w_a_dout;
    logic [DATA_W-1:0]   w_d_dout;
    logic                w_a_full, w_a_empty, w_d_full, w_d_empty;
    logic [c_CNT_FW-1:0] w_a_count, w_d_count;
    logic                w_pop, w_push_a, w_push_d, w_drop_a, w_drop_d;
    logic                w_slot_free, w_accept;
    logic                w_unused_counts;

    out_state_e          r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_addr_ovf, r_data_ovf;
    logic [CNT_W-1:0]    r_pair_count;

    // A beat may enter a full FIFO only when the pair pop frees a slot
    assign w_slot_free = (r_state == OUT_EMPTY) || bus.wr_ready;
    assign w_pop       = !w_a_empty && !w_d_empty && w_slot_free;
    assign w_push_a    = bus.valid_addr && (!w_a_full || w_pop);
    assign w_push_d    = bus.valid_data && (!w_d_full || w_pop);
    assign w_drop_a    = bus.valid_addr && w_a_full && !w_pop;
    assign w_drop_d    = bus.valid_data && w_d_full && !w_pop;
    assign w_accept    = (r_state == OUT_FULL) && bus.wr_ready;

    assign w_unused_counts = ^{w_a_count, w_d_count};

    ab_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_addr_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push_a),
        .pop   (w_pop),
        .din   (bus.address),
        .dout  (w_a_dout),
        .full  (w_a_full),
        .empty (w_a_empty),
        .count (w_a_count)
    );

    ab_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_data_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push_d),
        .pop   (w_pop),
        .din   (bus.data),
        .dout  (w_d_dout),
        .full  (w_d_full),
        .empty (w_d_empty),
        .count (w_d_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OUT_EMPTY: if (w_pop) w_state_nxt = OUT_FULL;
            OUT_FULL:  if (bus.wr_ready && !w_pop) w_state_nxt = OUT_EMPTY;
            default:   w_state_nxt = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= OUT_EMPTY;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_addr_ovf   <= 1'b0;
            r_data_ovf   <= 1'b0;
            r_pair_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_wr_addr <= w_a_dout;
                r_wr_data <= w_d_dout;
            end
            // a drop in the clearing cycle keeps the flag set
            if (w_drop_a)     r_addr_ovf <= 1'b1;
            else if (clr_err) r_addr_ovf <= 1'b0;
            if (w_drop_d)     r_data_ovf <= 1'b1;
            else if (clr_err) r_data_ovf <= 1'b0;
            if (w_accept) r_pair_count <= r_pair_count + 1'b1;
        end
    end

    assign bus.wr_valid = (r_state == OUT_FULL);
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign addr_ovf     = r_addr_ovf;
    assign data_ovf     = r_data_ovf;
    assign pair_count   = r_pair_count;

endmodule

`default_nettype wire

// File: tb/tb_ab_req_pairer.sv
// ============================================================================
// Module      : tb_ab_req_pairer
// Description : Scenario tasks plus a queue-based reference model for ab_req_pairer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ab_req_pairer;
    localparam int AW    = 12;
    localparam int DW    = 24;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr_err;
    logic          addr_ovf, data_ovf;
    logic [CW-1:0] pair_count;

    int nvec = 0;
    int nerr = 0;

    ab_req_pairer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ab_req_pairer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .addr_ovf   (addr_ovf),
        .data_ovf   (data_ovf),
        .clr_err    (clr_err),
        .pair_count (pair_count)
    );

    always #5 clk = ~clk;

    // Reference model: two arrival queues and a one-entry output holder
    logic [AW-1:0] aq[$];
    logic [DW-1:0] dq[$];
    logic          m_valid = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;
    logic          m_aovf  = 1'b0, m_dovf = 1'b0;
    logic [CW-1:0] m_cnt   = '0;

    task automatic idle();
        bus.valid_addr = 1'b0; bus.valid_data = 1'b0;
        bus.address = '0; bus.data = '0; clr_err = 1'b0;
    endtask

    task automatic step();
        bit acc, pop, dropa, dropd;
        if (!rst_n) begin
            aq.delete(); dq.delete();
            m_valid = 0; m_addr = '0; m_data = '0; m_aovf = 0; m_dovf = 0; m_cnt = '0;
        end else begin
            acc   = m_valid && bus.wr_ready;
            pop   = (aq.size() > 0) && (dq.size() > 0) && (!m_valid || bus.wr_ready);
            dropa = bus.valid_addr && (aq.size() == DEPTH) && !pop;
            dropd = bus.valid_data && (dq.size() == DEPTH) && !pop;
            if (acc) m_cnt = m_cnt + 1'b1;
            if (pop) begin
                m_addr = aq.pop_front(); m_data = dq.pop_front(); m_valid = 1;
            end else if (acc) m_valid = 0;
            if (bus.valid_addr && !dropa) aq.push_back(bus.address);
            if (bus.valid_data && !dropd) dq.push_back(bus.data);
            if (dropa) m_aovf = 1; else if (clr_err) m_aovf = 0;
            if (dropd) m_dovf = 1; else if (clr_err) m_dovf = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle(); bus.wr_ready = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle(); bus.wr_ready = 1'b0; rst_n = 1'b0;
        step(); step();
        nvec++;
        if ({bus.wr_valid, bus.wr_addr, bus.wr_data, addr_ovf, data_ovf, pair_count} !== '0) begin
            nerr++;
            $display("FAIL reset: got v=%b a=%h d=%h ao=%b do=%b cnt=%0d, want all zero",
                     bus.wr_valid, bus.wr_addr, bus.wr_data, addr_ovf, data_ovf, pair_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_same_cycle();
        do_reset();
        bus.wr_ready = 1'b1;
        repeat (3) step();
        bus.valid_addr = 1'b1; bus.address = 12'h123;
        bus.valid_data = 1'b1; bus.data = 24'hABCDEF;
        step();
        idle();
        nvec++;
        if (bus.wr_valid !== 1'b0) begin
            nerr++; $display("FAIL same_cycle_early: wr_valid=%b want 0", bus.wr_valid);
        end
        step();
        nvec++;
        if ({bus.wr_valid, bus.wr_addr, bus.wr_data} !== {1'b1, 12'h123, 24'hABCDEF}) begin
            nerr++;
            $display("FAIL same_cycle_pair: got v=%b a=%h d=%h want 1/123/abcdef",
                     bus.wr_valid, bus.wr_addr, bus.wr_data);
        end
        step();
        nvec++;
        if (pair_count !== 4'd1 || bus.wr_valid !== 1'b0) begin
            nerr++; $display("FAIL same_cycle_count: cnt=%0d v=%b want 1/0", pair_count, bus.wr_valid);
        end
    endtask

    task automatic test_ordered();
        logic [AW+DW-1:0] got[$];
        int               cyc[$];
        int               t = 0;
        do_reset();
        bus.wr_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            idle();
            if (i < 4) begin bus.valid_addr = 1'b1; bus.address = AW'(i + 1); end
            if (i >= 14) begin bus.valid_data = 1'b1; bus.data = DW'((i - 13) * 16); end
            step(); t++;
            if (bus.wr_valid) begin got.push_back({bus.wr_addr, bus.wr_data}); cyc.push_back(t); end
        end
        idle();
        for (int i = 0; i < 6; i++) begin
            step(); t++;
            if (bus.wr_valid) begin got.push_back({bus.wr_addr, bus.wr_data}); cyc.push_back(t); end
        end
        nvec++;
        if (got.size() != 4) begin
            nerr++; $display("FAIL ordered_count: got %0d pairs want 4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                nvec++;
                if (got[k] !== {AW'(k + 1), DW'((k + 1) * 16)} || (k > 0 && cyc[k] != cyc[k-1] + 1)) begin
                    nerr++;
                    $display("FAIL ordered_pair%0d: got %h at t=%0d want %h consecutive",
                             k, got[k], cyc[k], {AW'(k + 1), DW'((k + 1) * 16)});
                end
            end
        end
        nvec++;
        if ({addr_ovf, data_ovf} !== 2'b00) begin
            nerr++; $display("FAIL ordered_flags: ao=%b do=%b want 0/0", addr_ovf, data_ovf);
        end
    endtask

    task automatic test_overflow();
        logic [AW+DW-1:0] got[$];
        do_reset();
        bus.wr_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            idle(); bus.valid_addr = 1'b1; bus.address = AW'(i);
            step();
            if (i == 8) begin
                nvec++;
                if (addr_ovf !== 1'b0) begin nerr++; $display("FAIL ovf_at8: addr_ovf=%b want 0", addr_ovf); end
            end
        end
        nvec++;
        if ({addr_ovf, data_ovf} !== 2'b10) begin
            nerr++; $display("FAIL ovf_at9: ao=%b do=%b want 1/0", addr_ovf, data_ovf);
        end
        idle(); bus.valid_addr = 1'b1; bus.address = 12'hFFF; clr_err = 1'b1;
        step();
        nvec++;
        if (addr_ovf !== 1'b1) begin nerr++; $display("FAIL ovf_drop_vs_clr: addr_ovf=%b want 1", addr_ovf); end
        bus.wr_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            idle();
            if (i <= 8) begin bus.valid_data = 1'b1; bus.data = DW'(12'h100 + i); end
            step();
            if (bus.wr_valid) got.push_back({bus.wr_addr, bus.wr_data});
        end
        nvec++;
        if (got.size() != 8) begin
            nerr++; $display("FAIL ovf_pairs: got %0d pairs want 8", got.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                nvec++;
                if (got[k] !== {AW'(k + 1), DW'(12'h101 + k)}) begin
                    nerr++; $display("FAIL ovf_pair%0d: got %h want %h", k, got[k], {AW'(k + 1), DW'(12'h101 + k)});
                end
            end
        end
        nvec++;
        if (addr_ovf !== 1'b1) begin nerr++; $display("FAIL ovf_sticky: addr_ovf=%b want 1", addr_ovf); end
        idle(); clr_err = 1'b1;
        step();
        idle();
        nvec++;
        if ({addr_ovf, data_ovf} !== 2'b00) begin
            nerr++; $display("FAIL ovf_clear: ao=%b do=%b want 0/0", addr_ovf, data_ovf);
        end
    endtask

    task automatic test_stall();
        logic [AW+DW-1:0] exp[$];
        logic [AW+DW-1:0] got[$];
        logic [AW+DW-1:0] hold;
        do_reset();
        bus.wr_ready = 1'b1;
        bus.valid_addr = 1'b1; bus.address = 12'h0AA;
        bus.valid_data = 1'b1; bus.data = 24'h0000BB;
        step();
        idle(); step();
        bus.wr_ready = 1'b0;
        hold = {bus.wr_addr, bus.wr_data};
        exp.push_back({12'h0AA, 24'h0000BB});
        for (int k = 0; k < 6; k++) begin
            bus.valid_addr = 1'b1; bus.address = AW'($urandom);
            bus.valid_data = 1'b1; bus.data = DW'($urandom);
            exp.push_back({bus.address, bus.data});
            step();
            nvec++;
            if (bus.wr_valid !== 1'b1 || {bus.wr_addr, bus.wr_data} !== {12'h0AA, 24'h0000BB}) begin
                nerr++;
                $display("FAIL stall_hold%0d: v=%b out=%h want 1/%h (held %h)", k, bus.wr_valid,
                         {bus.wr_addr, bus.wr_data}, {12'h0AA, 24'h0000BB}, hold);
            end
        end
        idle(); bus.wr_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (bus.wr_valid) got.push_back({bus.wr_addr, bus.wr_data});
            step();
        end
        nvec++;
        if (got.size() != exp.size()) begin
            nerr++; $display("FAIL stall_drain_count: got %0d want %0d", got.size(), exp.size());
        end else begin
            for (int k = 0; k < exp.size(); k++) begin
                nvec++;
                if (got[k] !== exp[k]) begin
                    nerr++; $display("FAIL stall_drain%0d: got %h want %h", k, got[k], exp[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.wr_ready = 1'b0;
        bus.valid_addr = 1'b1; bus.address = 12'h001;
        bus.valid_data = 1'b1; bus.data = 24'h000002;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            bus.valid_addr = 1'b1; bus.address = AW'(12'h300 + i);
            step();
        end
        idle(); rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        nvec++;
        if ({bus.wr_valid, bus.wr_addr, bus.wr_data, addr_ovf, data_ovf, pair_count} !== '0) begin
            nerr++;
            $display("FAIL reset_mid: got v=%b a=%h d=%h cnt=%0d want all zero",
                     bus.wr_valid, bus.wr_addr, bus.wr_data, pair_count);
        end
        bus.wr_ready = 1'b1;
        bus.valid_addr = 1'b1; bus.address = 12'h007;
        bus.valid_data = 1'b1; bus.data = 24'h000008;
        step();
        idle(); step();
        nvec++;
        if ({bus.wr_valid, bus.wr_addr, bus.wr_data} !== {1'b1, 12'h007, 24'h000008}) begin
            nerr++;
            $display("FAIL reset_mid_fresh: got v=%b a=%h d=%h want 1/007/000008",
                     bus.wr_valid, bus.wr_addr, bus.wr_data);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.wr_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.valid_addr = 1'b1; bus.address = AW'($urandom);
            bus.valid_data = 1'b1; bus.data = DW'($urandom);
            step();
        end
        idle();
        repeat (3) step();
        nvec++;
        if (pair_count !== 4'd1) begin
            nerr++; $display("FAIL wrap: pair_count=%0d want 1", pair_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bus.valid_addr = ($urandom_range(0, 99) < 55);
            bus.address    = AW'($urandom);
            bus.valid_data = ($urandom_range(0, 99) < 50);
            bus.data       = DW'($urandom);
            bus.wr_ready   = ((c / 40) % 2 == 0) ? ($urandom_range(0, 99) < 80)
                                                 : ($urandom_range(0, 99) < 15);
            clr_err        = ($urandom_range(0, 99) < 6);
            step();
            nvec++;
            if ({bus.wr_valid, bus.wr_addr, bus.wr_data, addr_ovf, data_ovf, pair_count} !==
                {m_valid, m_addr, m_data, m_aovf, m_dovf, m_cnt}) begin
                nerr++;
                $display("FAIL random c=%0d: got v=%b a=%h d=%h ao=%b do=%b cnt=%0d want v=%b a=%h d=%h ao=%b do=%b cnt=%0d",
                         c, bus.wr_valid, bus.wr_addr, bus.wr_data, addr_ovf, data_ovf, pair_count,
                         m_valid, m_addr, m_data, m_aovf, m_dovf, m_cnt);
            end
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.wr_ready = 1'b0;
        idle();
        test_reset();
        test_same_cycle();
        test_ordered();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
